// File: rtl/audio_pkg.sv
// Shared types and unit-conversion helpers for the audio event path.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NOTE = 2'd1,
    MUTE = 2'd2
  } state_t;

  localparam int NOTE_COUNT = 4;

  function automatic int ms_to_cycles(input int clk_freq, input int ms);
    return clk_freq / 1000 * ms;
  endfunction

  function automatic int hz_to_period(input int clk_freq, input int hz);
    return clk_freq / hz;
  endfunction

endpackage

// File: rtl/fleet_note_sequencer.sv
// Four-note fleet march: each step plays the next note for NOTE_MS, then silence.
// Period updates 1 cycle after step/enable/mute; enable-low and mute both silence at once.
module fleet_note_sequencer
  import audio_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int NOTE_MS   = 100,
  parameter int NOTE_0_HZ = 62,
  parameter int NOTE_1_HZ = 56,
  parameter int NOTE_2_HZ = 52,
  parameter int NOTE_3_HZ = 48,
  parameter int TIMER_W   = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic        enable,
  input  logic        mute,
  output logic [31:0] period,
  output logic        note_last
);

  localparam int NOTE_CYC = ms_to_cycles(CLK_FREQ, NOTE_MS);
  localparam logic [TIMER_W-1:0] NOTE_LOAD = TIMER_W'(NOTE_CYC - 1);
  localparam logic [31:0] PER_0 = 32'(hz_to_period(CLK_FREQ, NOTE_0_HZ));
  localparam logic [31:0] PER_1 = 32'(hz_to_period(CLK_FREQ, NOTE_1_HZ));
  localparam logic [31:0] PER_2 = 32'(hz_to_period(CLK_FREQ, NOTE_2_HZ));
  localparam logic [31:0] PER_3 = 32'(hz_to_period(CLK_FREQ, NOTE_3_HZ));

  logic [1:0]         idx_q, idx_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               active_q, active_d;
  logic [31:0]        period_q, period_d;
  logic [31:0]        per_sel;

  always_comb begin
    case (idx_q)
      2'd0:    per_sel = PER_0;
      2'd1:    per_sel = PER_1;
      2'd2:    per_sel = PER_2;
      default: per_sel = PER_3;
    endcase
  end

  // Enable-low outranks mute so the march restarts from note 0 after game over.
  always_comb begin
    idx_d    = idx_q;
    timer_d  = timer_q;
    active_d = active_q;
    period_d = period_q;
    if (!enable) begin
      idx_d    = '0;
      timer_d  = '0;
      active_d = 1'b0;
      period_d = '0;
    end else if (mute) begin
      timer_d  = '0;
      active_d = 1'b0;
      period_d = '0;
    end else if (step) begin
      period_d = per_sel;
      idx_d    = (idx_q == 2'(NOTE_COUNT - 1)) ? 2'd0 : idx_q + 2'd1;
      timer_d  = NOTE_LOAD;
      active_d = 1'b1;
    end else if (active_q) begin
      if (timer_q == '0) begin
        active_d = 1'b0;
        period_d = '0;
      end else begin
        timer_d = timer_q - TIMER_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      timer_q  <= '0;
      active_q <= 1'b0;
      period_q <= '0;
    end else begin
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      active_q <= active_d;
      period_q <= period_d;
    end
  end

  assign period    = period_q;
  assign note_last = active_q & (timer_q == '0);

endmodule

// File: rtl/audio_event_controller.sv
// Turns game events into one-cycle audio_unit pulses plus the fleet_period word.
// Every output is registered, 1 cycle after its cause; a player hit mutes fleet and shots.
module audio_event_controller
  import audio_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int NOTE_MS   = 100,
  parameter int MUTE_MS   = 1000,
  parameter int NOTE_0_HZ = 62,
  parameter int NOTE_1_HZ = 56,
  parameter int NOTE_2_HZ = 52,
  parameter int NOTE_3_HZ = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fleet_enable,
  input  logic        fleet_step,
  input  logic        ufo_active,
  input  logic        shot_fired,
  input  logic        player_hit,
  input  logic        alien_hit,
  input  logic        ufo_hit,
  output logic [31:0] fleet_period,
  output logic        play_ufo,
  output logic        stop_ufo,
  output logic        play_shoot,
  output logic        play_player_hit,
  output logic        play_alien_hit,
  output logic        play_ufo_hit
);

  localparam int NOTE_CYC = ms_to_cycles(CLK_FREQ, NOTE_MS);
  localparam int MUTE_CYC = ms_to_cycles(CLK_FREQ, MUTE_MS);
  localparam int MAX_CYC  = (NOTE_CYC > MUTE_CYC) ? NOTE_CYC : MUTE_CYC;
  localparam int TIMER_W  = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TIMER_W-1:0] MUTE_LOAD = TIMER_W'(MUTE_CYC - 1);

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] mute_timer_q, mute_timer_d;
  logic               ufo_prev_q, ufo_pending_q, ufo_pending_d;
  logic               play_ufo_q, stop_ufo_q, play_shoot_q;
  logic               play_player_hit_q, play_alien_hit_q, play_ufo_hit_q;
  logic               play_ufo_d, stop_ufo_d, play_shoot_d;
  logic               in_mute, mute_exit, ufo_rise, ufo_fall, note_last;

  fleet_note_sequencer #(
    .CLK_FREQ (CLK_FREQ),
    .NOTE_MS  (NOTE_MS),
    .NOTE_0_HZ(NOTE_0_HZ),
    .NOTE_1_HZ(NOTE_1_HZ),
    .NOTE_2_HZ(NOTE_2_HZ),
    .NOTE_3_HZ(NOTE_3_HZ),
    .TIMER_W  (TIMER_W)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .step     (fleet_step),
    .enable   (fleet_enable),
    .mute     (player_hit | in_mute),
    .period   (fleet_period),
    .note_last(note_last)
  );

  assign in_mute   = (state_q == MUTE);
  assign mute_exit = in_mute & ~player_hit & ((mute_timer_q == '0) | ~fleet_enable);
  assign ufo_rise  = ufo_active & ~ufo_prev_q;
  assign ufo_fall  = ~ufo_active & ufo_prev_q;

  always_comb begin
    state_d      = state_q;
    mute_timer_d = mute_timer_q;
    if (player_hit) begin
      state_d      = MUTE;
      mute_timer_d = MUTE_LOAD;
    end else if (!fleet_enable) begin
      state_d      = IDLE;
      mute_timer_d = '0;
    end else begin
      case (state_q)
        MUTE: begin
          if (mute_timer_q == '0) state_d = IDLE;
          else mute_timer_d = mute_timer_q - TIMER_W'(1);
        end
        NOTE: begin
          if (fleet_step) state_d = NOTE;
          else if (note_last) state_d = IDLE;
        end
        default: begin
          if (fleet_step) state_d = NOTE;
        end
      endcase
    end
  end

  // A UFO that appeared during the mute is announced on the last mute cycle; stop always wins.
  always_comb begin
    stop_ufo_d    = ufo_fall | ufo_hit | player_hit;
    play_ufo_d    = ~stop_ufo_d &
                    ((ufo_rise & ~in_mute) |
                     (mute_exit & ufo_active & (ufo_pending_q | ufo_rise)));
    play_shoot_d  = shot_fired & ~in_mute & ~player_hit;
    ufo_pending_d = ufo_pending_q;
    if (stop_ufo_d | mute_exit) ufo_pending_d = 1'b0;
    else if (ufo_rise & in_mute) ufo_pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      mute_timer_q      <= '0;
      ufo_prev_q        <= 1'b0;
      ufo_pending_q     <= 1'b0;
      play_ufo_q        <= 1'b0;
      stop_ufo_q        <= 1'b0;
      play_shoot_q      <= 1'b0;
      play_player_hit_q <= 1'b0;
      play_alien_hit_q  <= 1'b0;
      play_ufo_hit_q    <= 1'b0;
    end else begin
      state_q           <= state_d;
      mute_timer_q      <= mute_timer_d;
      ufo_prev_q        <= ufo_active;
      ufo_pending_q     <= ufo_pending_d;
      play_ufo_q        <= play_ufo_d;
      stop_ufo_q        <= stop_ufo_d;
      play_shoot_q      <= play_shoot_d;
      play_player_hit_q <= player_hit;
      play_alien_hit_q  <= alien_hit;
      play_ufo_hit_q    <= ufo_hit;
    end
  end

  assign play_ufo        = play_ufo_q;
  assign stop_ufo        = stop_ufo_q;
  assign play_shoot      = play_shoot_q;
  assign play_player_hit = play_player_hit_q;
  assign play_alien_hit  = play_alien_hit_q;
  assign play_ufo_hit    = play_ufo_hit_q;

endmodule

// File: tb/tb_audio_event_controller.sv
// Directed scenarios plus a randomized run against a remaining-cycles reference model.
module tb_audio_event_controller;

  localparam int NOTE_CYC = 10;
  localparam int MUTE_CYC = 50;

  logic clk = 1'b0;
  logic rst = 1'b1, fleet_enable = 1'b0, fleet_step = 1'b0, ufo_active = 1'b0;
  logic shot_fired = 1'b0, player_hit = 1'b0, alien_hit = 1'b0, ufo_hit = 1'b0;
  logic [31:0] fleet_period;
  logic play_ufo, stop_ufo, play_shoot, play_player_hit, play_alien_hit, play_ufo_hit;

  int checks = 0;
  int failures = 0;
  int per_tab[4] = '{10, 20, 40, 50};

  // Reference model state: counts of cycles still to go, not timer encodings.
  int m_mute_left = 0, m_note_left = 0, m_idx = 0;
  logic [31:0] m_per = '0;
  logic m_prev = 1'b0, m_pend = 1'b0;
  logic [37:0] exp_vec = '0;

  audio_event_controller #(
    .CLK_FREQ(1000), .NOTE_MS(10), .MUTE_MS(50),
    .NOTE_0_HZ(100), .NOTE_1_HZ(50), .NOTE_2_HZ(25), .NOTE_3_HZ(20)
  ) dut (
    .clk(clk), .rst(rst), .fleet_enable(fleet_enable), .fleet_step(fleet_step),
    .ufo_active(ufo_active), .shot_fired(shot_fired), .player_hit(player_hit),
    .alien_hit(alien_hit), .ufo_hit(ufo_hit), .fleet_period(fleet_period),
    .play_ufo(play_ufo), .stop_ufo(stop_ufo), .play_shoot(play_shoot),
    .play_player_hit(play_player_hit), .play_alien_hit(play_alien_hit),
    .play_ufo_hit(play_ufo_hit)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] obs();
    return {fleet_period, play_ufo, stop_ufo, play_shoot, play_player_hit,
            play_alien_hit, play_ufo_hit};
  endfunction

  task automatic model_step();
    logic in_mute, rise, fall, exiting, stop, play;
    if (rst) begin
      m_mute_left = 0; m_note_left = 0; m_idx = 0; m_per = '0;
      m_prev = 1'b0; m_pend = 1'b0; exp_vec = '0;
      return;
    end
    in_mute = (m_mute_left > 0);
    rise    = ufo_active && !m_prev;
    fall    = !ufo_active && m_prev;
    exiting = in_mute && !player_hit && (m_mute_left == 1 || !fleet_enable);
    stop    = fall || ufo_hit || player_hit;
    play    = !stop && ((rise && !in_mute) || (exiting && ufo_active && (m_pend || rise)));
    if (stop || exiting) m_pend = 1'b0;
    else if (rise && in_mute) m_pend = 1'b1;
    m_prev = ufo_active;
    exp_vec = {32'd0, play, stop, shot_fired && !in_mute && !player_hit,
               player_hit, alien_hit, ufo_hit};
    if (player_hit) begin
      m_mute_left = MUTE_CYC; m_note_left = 0; m_per = '0;
      if (!fleet_enable) m_idx = 0;
    end else if (!fleet_enable) begin
      m_mute_left = 0; m_note_left = 0; m_per = '0; m_idx = 0;
    end else if (in_mute) begin
      m_mute_left--;
    end else if (fleet_step) begin
      m_per = 32'(per_tab[m_idx]);
      m_idx = (m_idx + 1) % 4;
      m_note_left = NOTE_CYC;
    end else if (m_note_left > 0) begin
      m_note_left--;
      if (m_note_left == 0) m_per = '0;
    end
    exp_vec[37:6] = m_per;
  endtask

  // Advance one clock; afterwards outputs reflect the inputs of the cycle just ended.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    fleet_step = 1'b0; shot_fired = 1'b0; player_hit = 1'b0;
    alien_hit = 1'b0; ufo_hit = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (obs() !== 38'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", obs());
    end
    rst = 1'b0;
    fleet_enable = 1'b1;
    tick();
  endtask

  task automatic test_note_sequence();
    for (int k = 0; k < 5; k++) begin
      fleet_step = 1'b1;
      for (int c = 1; c <= 20; c++) begin
        tick();
        checks++;
        if (fleet_period !== ((c <= NOTE_CYC) ? 32'(per_tab[k % 4]) : 32'd0)) begin
          failures++;
          $display("FAIL seq_note%0d_c%0d: got %0d expected %0d", k, c, fleet_period,
                   (c <= NOTE_CYC) ? per_tab[k % 4] : 0);
        end
      end
    end
  endtask

  task automatic test_retrigger_enable();
    fleet_enable = 1'b0;
    tick();
    fleet_enable = 1'b1;
    fleet_step = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      if (c == 5) fleet_step = 1'b1;
      tick();
      checks++;
      if (fleet_period !== ((c <= 4) ? 32'd10 : (c <= 14) ? 32'd20 : 32'd0)) begin
        failures++;
        $display("FAIL retrig_c%0d: got %0d", c, fleet_period);
      end
    end
    fleet_step = 1'b1;
    tick(); tick(); tick();
    fleet_enable = 1'b0;
    tick();
    checks++;
    if (fleet_period !== 32'd0) begin
      failures++;
      $display("FAIL disable_silence: got %0d expected 0", fleet_period);
    end
    fleet_enable = 1'b1;
    fleet_step = 1'b1;
    tick();
    checks++;
    if (fleet_period !== 32'd10) begin
      failures++;
      $display("FAIL reenable_note0: got %0d expected 10", fleet_period);
    end
    repeat (NOTE_CYC) tick();
  endtask

  task automatic test_player_mute();
    player_hit = 1'b1;
    fleet_step = 1'b1;
    tick();
    checks++;
    if (play_player_hit !== 1'b1 || stop_ufo !== 1'b1 || fleet_period !== 32'd0) begin
      failures++;
      $display("FAIL hit_pulses: got php=%b stop=%b per=%0d expected 1 1 0",
               play_player_hit, stop_ufo, fleet_period);
    end
    for (int i = 1; i <= MUTE_CYC; i++) begin
      fleet_step = (i % 7 == 0) || (i == MUTE_CYC);
      shot_fired = (i % 5 == 0) || (i == 1);
      tick();
      checks++;
      if (fleet_period !== 32'd0 || play_shoot !== 1'b0) begin
        failures++;
        $display("FAIL mute_i%0d: got per=%0d shoot=%b expected 0 0", i, fleet_period, play_shoot);
      end
    end
    fleet_step = 1'b1;
    shot_fired = 1'b1;
    tick();
    checks++;
    if (fleet_period !== 32'd20 || play_shoot !== 1'b1) begin
      failures++;
      $display("FAIL post_mute: got per=%0d shoot=%b expected 20 1", fleet_period, play_shoot);
    end
    repeat (NOTE_CYC) tick();
  endtask

  task automatic test_ufo_pending();
    int plays, stops;
    player_hit = 1'b1;
    tick();
    for (int c = 1; c <= 51; c++) begin
      if (c == 5) ufo_active = 1'b1;
      tick();
      checks++;
      if (play_ufo !== ((c + 1 == 51) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL ufo_deferred_c%0d: got %b expected %b", c + 1, play_ufo, (c + 1 == 51));
      end
    end
    ufo_active = 1'b0;
    tick();
    player_hit = 1'b1;
    tick();
    plays = 0; stops = 0;
    for (int c = 1; c <= 51; c++) begin
      if (c == 5) ufo_active = 1'b1;
      if (c == 20) ufo_active = 1'b0;
      tick();
      plays += int'(play_ufo);
      stops += int'(stop_ufo);
    end
    checks++;
    if (plays != 0 || stops != 1) begin
      failures++;
      $display("FAIL ufo_gone_in_mute: got plays=%0d stops=%0d expected 0 1", plays, stops);
    end
  endtask

  task automatic test_hits();
    ufo_active = 1'b1;
    tick();
    checks++;
    if (play_ufo !== 1'b1 || stop_ufo !== 1'b0) begin
      failures++;
      $display("FAIL ufo_rise: got play=%b stop=%b expected 1 0", play_ufo, stop_ufo);
    end
    tick();
    ufo_hit = 1'b1;
    ufo_active = 1'b0;
    tick();
    checks++;
    if (play_ufo_hit !== 1'b1 || stop_ufo !== 1'b1) begin
      failures++;
      $display("FAIL ufo_hit_fall: got hit=%b stop=%b expected 1 1", play_ufo_hit, stop_ufo);
    end
    tick();
    checks++;
    if (play_ufo_hit !== 1'b0 || stop_ufo !== 1'b0) begin
      failures++;
      $display("FAIL single_stop: got hit=%b stop=%b expected 0 0", play_ufo_hit, stop_ufo);
    end
    player_hit = 1'b1;
    tick();
    repeat (3) tick();
    alien_hit = 1'b1;
    tick();
    checks++;
    if (play_alien_hit !== 1'b1) begin
      failures++;
      $display("FAIL alien_in_mute: got %b expected 1", play_alien_hit);
    end
    repeat (MUTE_CYC) tick();
  endtask

  task automatic test_reset_abort();
    fleet_step = 1'b1;
    tick();
    checks++;
    if (fleet_period !== 32'd40) begin
      failures++;
      $display("FAIL pre_abort_note: got %0d expected 40", fleet_period);
    end
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (obs() !== 38'd0) begin
      failures++;
      $display("FAIL reset_mid_note: got %h expected 0", obs());
    end
    rst = 1'b0;
    fleet_step = 1'b1;
    tick();
    checks++;
    if (fleet_period !== 32'd10) begin
      failures++;
      $display("FAIL note_after_reset: got %0d expected 10", fleet_period);
    end
    player_hit = 1'b1;
    ufo_active = 1'b1;
    tick();
    repeat (5) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (obs() !== 38'd0) begin
      failures++;
      $display("FAIL reset_mid_mute: got %h expected 0", obs());
    end
    rst = 1'b0;
    fleet_step = 1'b1;
    tick();
    checks++;
    if (fleet_period !== 32'd10 || play_ufo !== 1'b1) begin
      failures++;
      $display("FAIL after_mute_reset: got per=%0d play_ufo=%b expected 10 1",
               fleet_period, play_ufo);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 4000; n++) begin
      rst          = ($urandom_range(999) == 0);
      fleet_enable = ($urandom_range(24) != 0);
      fleet_step   = ($urandom_range(11) == 0);
      shot_fired   = ($urandom_range(7) == 0);
      player_hit   = ($urandom_range(149) == 0);
      alien_hit    = ($urandom_range(9) == 0);
      ufo_hit      = ($urandom_range(39) == 0);
      if ($urandom_range(29) == 0) ufo_active = ~ufo_active;
      tick();
      checks++;
      if (obs() !== exp_vec) begin
        failures++;
        bad++;
        if (bad <= 10) $display("FAIL random_n%0d: got %h expected %h", n, obs(), exp_vec);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_note_sequence();
    test_retrigger_enable();
    test_player_mute();
    test_ufo_pending();
    test_hits();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_event_controller.md
Name: audio_event_controller

Overview:
- Sits directly upstream of audio_unit.
- Converts raw game events into the single-cycle play/stop pulses and the fleet_period word that audio_unit consumes.
- Sequences the four-note fleet march: one note per fleet step, each held for a fixed duration, then silence.
- Applies a player-death mute window that silences the fleet and the shot sound, and defers UFO restart until the window ends.

Parameters:
- CLK_FREQ, 100_000_000, clk frequency in Hz.
- NOTE_MS, 100, duration of each fleet note in ms.
- MUTE_MS, 1000, fleet/shot mute window after a player hit, in ms.
- NOTE_0_HZ, 62, tone of fleet note 0.
- NOTE_1_HZ, 56, tone of fleet note 1.
- NOTE_2_HZ, 52, tone of fleet note 2.
- NOTE_3_HZ, 48, tone of fleet note 3.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- fleet_enable  in  1  level; low = fleet sound off (attract/game over)
- fleet_step  in  1  one-cycle pulse per fleet move
- ufo_active  in  1  level; high while UFO is on screen
- shot_fired  in  1  pulse, player shot
- player_hit  in  1  pulse
- alien_hit  in  1  pulse
- ufo_hit  in  1  pulse
- fleet_period  out  32  full square-wave period in clk cycles; 0 = silence
- play_ufo, stop_ufo, play_shoot, play_player_hit, play_alien_hit, play_ufo_hit  out  1 each  one-cycle pulses

Behaviour:
- All outputs are registered; reset value is 0 for every output.
- Reset also clears: note index to 0, both timers, ufo_active history register, ufo_pending, FSM to IDLE.
- Reset mid-note or mid-mute aborts immediately.
- Derived constants: NOTE_CYC = CLK_FREQ/1000*NOTE_MS; MUTE_CYC = CLK_FREQ/1000*MUTE_MS; PER_k = CLK_FREQ/NOTE_k_HZ (integer division, truncating).
- Fleet period 0 is the silence convention: square_wave_generator holds its output low for period 0.
- FSM states: IDLE, NOTE, MUTE.
- IDLE: fleet_period = 0.
  - fleet_step & fleet_enable -> NOTE; fleet_period <= PER[idx]; idx <= idx+1 (mod 4, wraps 3->0); timer <= NOTE_CYC-1.
- NOTE: timer decrements each cycle.
  - Timer reaching 0 -> IDLE, fleet_period <= 0.
  - A new fleet_step retriggers with the next note and reloads the timer.
- Any state: fleet_enable low -> IDLE, fleet_period <= 0, idx <= 0. This has priority over fleet_step.
- player_hit (any state, highest priority) -> MUTE; timer <= MUTE_CYC-1; fleet_period <= 0.
- MUTE: fleet_step and shot_fired are ignored; idx does not advance.
  - Timer reaching 0 -> IDLE.
  - A further player_hit in MUTE reloads the timer.
- Latency: every pulse output and every fleet_period change appears exactly 1 cycle after the causing input cycle.
- play_player_hit = player_hit, delayed 1 cycle.
- play_alien_hit = alien_hit, delayed 1 cycle, never suppressed.
- play_ufo_hit = ufo_hit, delayed 1 cycle.
- play_shoot = shot_fired & (state != MUTE) & ~player_hit, delayed 1 cycle.
- UFO rising edge of ufo_active:
  - Outside MUTE: play_ufo pulse.
  - Inside MUTE: sets ufo_pending, no pulse.
  - On MUTE exit, if ufo_pending & ufo_active: play_ufo pulse on the exit cycle+1, then ufo_pending cleared.
- stop_ufo pulses on any of:
  - falling edge of ufo_active;
  - ufo_hit;
  - player_hit.
  - These events are OR-ed, so coincident events give a single pulse.
  - ufo_pending is cleared by any of them.
- play_ufo and stop_ufo in the same cycle: stop wins, play suppressed.
- ufo_active high on the first cycle after reset counts as a rising edge.
- Width rules: timers are sized by $clog2 of the larger of NOTE_CYC and MUTE_CYC; fleet_period is zero-extended to 32 bits.

Decomposition:
- Shared package audio_pkg:
  - FSM state enum (IDLE/NOTE/MUTE);
  - NOTE_COUNT = 4;
  - ms_to_cycles(clk_freq, ms) function;
  - hz_to_period(clk_freq, hz) function.
- Sub-module fleet_note_sequencer:
  - owns idx, the note timer and the PER lookup;
  - inputs: step, enable, mute;
  - output: period.
- Top level keeps the MUTE timer, edge detection and pulse logic.

Test Plan:
- Bench parameters: CLK_FREQ=1000, NOTE_MS=10, MUTE_MS=50, NOTE_k_HZ=100/50/25/20 (PER = 10/20/40/50).
- Scenario 1: reset, enable=1, five fleet_step pulses spaced 20 cycles -> fleet_period 10,20,40,50,10. Each value lasts exactly 10 cycles starting 1 cycle after the step, then returns to 0.
- Scenario 2: two fleet_steps 4 cycles apart -> period 10 for 4 cycles, then 20 for 10 cycles, then 0 (retrigger). Then drop fleet_enable mid-note -> period 0 next cycle, and the next step after re-enable gives 10.
- Scenario 3: player_hit and fleet_step in the same cycle -> play_player_hit and stop_ufo pulse, period stays 0. Steps and shot_fired during the following 50 cycles produce nothing. A step at cycle 51 gives the next unplayed note.
- Scenario 4: ufo_active rises 5 cycles into MUTE and stays high -> no play_ufo during MUTE; one play_ufo 1 cycle after MUTE exit. A variant with ufo_active falling before exit -> one stop_ufo, no play_ufo.
- Scenario 5: ufo_hit coincident with ufo_active falling -> one play_ufo_hit and exactly one stop_ufo pulse. alien_hit during MUTE -> play_alien_hit still issued.
- Scenario 6: assert rst mid-NOTE and mid-MUTE -> all outputs 0 next cycle; the first step afterwards gives period 10 (idx back at 0).
